// File: rtl/rob_arith_slice_pkg.sv
// Shared constants for the Robertson multiplier arithmetic/control slice.
package rob_pkg;

  localparam int unsigned ROB_WIDTH     = 8;
  localparam int unsigned ROB_CNT_WIDTH = 3;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam logic [ROB_CNT_WIDTH-1:0] CNT_INIT = '1;

endpackage

// File: rtl/rob_arith_slice_if.sv
// Signal bundle for the slice: add/sub operands, counter controls and mux paths.
interface rob_arith_slice_if
  import rob_pkg::*;
#(
  parameter int unsigned WIDTH     = ROB_WIDTH,
  parameter int unsigned CNT_WIDTH = ROB_CNT_WIDTH
);

  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 sub;
  logic [WIDTH-1:0]     alu_out;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 cnt_zero;
  logic [WIDTH-1:0]     mux_d0;
  logic [WIDTH-1:0]     mux_d1;
  logic                 mux_sel;
  logic [WIDTH-1:0]     mux_y;

  modport master (
    output op_a, op_b, sub, cnt_load, cnt_dec, mux_d0, mux_d1, mux_sel,
    input  alu_out, cnt_q, cnt_zero, mux_y
  );

  modport slave (
    input  op_a, op_b, sub, cnt_load, cnt_dec, mux_d0, mux_d1, mux_sel,
    output alu_out, cnt_q, cnt_zero, mux_y
  );

endinterface

// File: rtl/rob_arith_slice_down_counter.sv
// Iteration down-counter: load-to-all-ones has priority over decrement; wraps at zero.
module rob_down_counter #(
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] q,
  output logic                 zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= '1;
    end else if (dec) begin
      q <= q - CNT_WIDTH'(1);
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/rob_arith_slice.sv
// Robertson multiplier slice: registered add/sub, iteration counter and operand mux.
module rob_arith_slice
  import rob_pkg::*;
#(
  parameter int unsigned WIDTH     = ROB_WIDTH,
  parameter int unsigned CNT_WIDTH = ROB_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  rob_arith_slice_if.slave bus
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.alu_out <= '0;
    end else if (op_e'(bus.sub) == OP_SUB) begin
      bus.alu_out <= bus.op_a - bus.op_b;
    end else begin
      bus.alu_out <= bus.op_a + bus.op_b;
    end
  end

  rob_down_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .load (bus.cnt_load),
    .dec  (bus.cnt_dec),
    .q    (bus.cnt_q),
    .zero (bus.cnt_zero)
  );

  // Conditional operator kept so an unknown select propagates rather than being masked.
  assign bus.mux_y = bus.mux_sel ? bus.mux_d1 : bus.mux_d0;

endmodule

// File: tb/tb_rob_arith_slice.sv
// Bench for rob_arith_slice against an arithmetic reference model.
module tb_rob_arith_slice;

  localparam int unsigned W = 8;
  localparam int unsigned C = 3;

  logic clk = 1'b0;
  logic reset;

  rob_arith_slice_if #(.WIDTH(W), .CNT_WIDTH(C)) bus ();

  rob_arith_slice #(.WIDTH(W), .CNT_WIDTH(C)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int exp_cnt;
  int exp_alu;

  function automatic int alu_ref(input int a, input int b, input bit s);
    int r;
    r = s ? (a - b) : (a + b);
    return ((r % 256) + 256) % 256;
  endfunction

  function automatic int cnt_ref(input int cur, input bit ld, input bit dc);
    if (ld) return 7;
    if (dc) return (cur + 7) % 8;
    return cur;
  endfunction

  function automatic int mux_ref(input bit s, input int d0, input int d1);
    if (s) return d1;
    return d0;
  endfunction

  // One clock with reset high: model advances from the inputs present at the edge.
  task automatic step();
    int pa, pc;
    pa = alu_ref(int'(bus.op_a), int'(bus.op_b), bus.sub);
    pc = cnt_ref(exp_cnt, bus.cnt_load, bus.cnt_dec);
    @(posedge clk);
    #1;
    exp_alu = pa;
    exp_cnt = pc;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.op_a = 8'($urandom); bus.op_b = 8'($urandom); bus.sub = 1'($urandom);
    bus.cnt_load = 1'b1; bus.cnt_dec = 1'b1;
    bus.mux_d0 = 8'($urandom); bus.mux_d1 = 8'($urandom); bus.mux_sel = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.alu_out !== 8'h00) begin errors++; $display("FAIL reset_alu actual=%h required=00", bus.alu_out); end
    vectors++;
    if (bus.cnt_q !== 3'd0) begin errors++; $display("FAIL reset_cnt actual=%0d required=0", bus.cnt_q); end
    vectors++;
    if (bus.cnt_zero !== 1'b1) begin errors++; $display("FAIL reset_zero actual=%b required=1", bus.cnt_zero); end
    bus.cnt_load = 1'b0; bus.cnt_dec = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.alu_out !== 8'h00 || bus.cnt_q !== 3'd0) begin
      errors++; $display("FAIL reset_release actual=%h/%0d required=00/0", bus.alu_out, bus.cnt_q);
    end
    exp_alu = 0;
    exp_cnt = 0;
  endtask

  task automatic test_addsub();
    logic [7:0] ta [4] = '{8'h05, 8'h05, 8'h00, 8'h7F};
    logic [7:0] tb [4] = '{8'h03, 8'h03, 8'h01, 8'h01};
    logic       ts [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] tr [4] = '{8'h08, 8'h02, 8'hFF, 8'h80};
    for (int i = 0; i < 4; i++) begin
      bus.op_a = ta[i]; bus.op_b = tb[i]; bus.sub = ts[i];
      #1;
      vectors++;
      if (int'(bus.alu_out) !== exp_alu) begin
        errors++; $display("FAIL addsub_latency%0d actual=%h required=%h", i, bus.alu_out, exp_alu);
      end
      step();
      vectors++;
      if (bus.alu_out !== tr[i]) begin
        errors++; $display("FAIL addsub%0d actual=%h required=%h", i, bus.alu_out, tr[i]);
      end
    end
  endtask

  task automatic test_count();
    bus.cnt_load = 1'b1; bus.cnt_dec = 1'b0;
    step();
    vectors++;
    if (bus.cnt_q !== 3'd7 || bus.cnt_zero !== 1'b0) begin
      errors++; $display("FAIL count_load actual=%0d/%b required=7/0", bus.cnt_q, bus.cnt_zero);
    end
    bus.cnt_load = 1'b0; bus.cnt_dec = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      int req;
      req = (i == 8) ? 7 : 7 - i;
      step();
      vectors++;
      if (int'(bus.cnt_q) !== req || bus.cnt_zero !== (req == 0)) begin
        errors++; $display("FAIL count_dec%0d actual=%0d/%b required=%0d/%b", i, bus.cnt_q, bus.cnt_zero, req, req == 0);
      end
    end
    bus.cnt_dec = 1'b0;
  endtask

  task automatic test_priority_hold();
    bus.cnt_load = 1'b1; step();
    bus.cnt_load = 1'b0; bus.cnt_dec = 1'b1;
    repeat (4) step();
    vectors++;
    if (bus.cnt_q !== 3'd3) begin errors++; $display("FAIL prio_setup actual=%0d required=3", bus.cnt_q); end
    bus.cnt_load = 1'b1; bus.cnt_dec = 1'b1;
    step();
    vectors++;
    if (bus.cnt_q !== 3'd7) begin errors++; $display("FAIL prio_load_wins actual=%0d required=7", bus.cnt_q); end
    bus.cnt_load = 1'b0; bus.cnt_dec = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (bus.cnt_q !== 3'd7) begin errors++; $display("FAIL hold%0d actual=%0d required=7", i, bus.cnt_q); end
    end
    bus.cnt_dec = 1'b1;
    repeat (3) step();
    bus.cnt_dec = 1'b0;
    vectors++;
    if (bus.cnt_q !== 3'd4) begin errors++; $display("FAIL async_setup actual=%0d required=4", bus.cnt_q); end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.cnt_q !== 3'd0 || bus.cnt_zero !== 1'b1 || bus.alu_out !== 8'h00) begin
      errors++; $display("FAIL async_reset actual=%0d/%b/%h required=0/1/00", bus.cnt_q, bus.cnt_zero, bus.alu_out);
    end
    bus.mux_d0 = 8'hC3; bus.mux_d1 = 8'h3C; bus.mux_sel = 1'b1;
    #1;
    vectors++;
    if (bus.mux_y !== 8'h3C) begin errors++; $display("FAIL mux_in_reset actual=%h required=3c", bus.mux_y); end
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 0;
    exp_alu = 0;
    step();
    vectors++;
    if (bus.cnt_q !== 3'd0) begin errors++; $display("FAIL restart_needs_load actual=%0d required=0", bus.cnt_q); end
  endtask

  task automatic test_mux();
    bus.mux_d0 = 8'hAA; bus.mux_d1 = 8'h55; bus.mux_sel = 1'b0;
    #1;
    vectors++;
    if (bus.mux_y !== 8'hAA) begin errors++; $display("FAIL mux_sel0 actual=%h required=aa", bus.mux_y); end
    bus.mux_sel = 1'b1;
    #1;
    vectors++;
    if (bus.mux_y !== 8'h55) begin errors++; $display("FAIL mux_sel1 actual=%h required=55", bus.mux_y); end
  endtask

  task automatic test_concurrent(input int cycles, input bit structured);
    for (int i = 0; i < cycles; i++) begin
      int em;
      if (structured) begin
        bus.cnt_load = (i == 0); bus.cnt_dec = (i != 0);
        bus.sub = 1'(i); bus.mux_sel = 1'(i + 1);
      end else begin
        bus.cnt_load = ($urandom_range(0, 7) == 0); bus.cnt_dec = 1'($urandom);
        bus.sub = 1'($urandom); bus.mux_sel = 1'($urandom);
      end
      bus.op_a = 8'($urandom); bus.op_b = 8'($urandom);
      bus.mux_d0 = 8'($urandom); bus.mux_d1 = 8'($urandom);
      #1;
      em = mux_ref(bus.mux_sel, int'(bus.mux_d0), int'(bus.mux_d1));
      vectors++;
      if (int'(bus.mux_y) !== em) begin
        errors++; $display("FAIL conc_mux%0d actual=%h required=%h", i, bus.mux_y, em);
      end
      step();
      vectors++;
      if (int'(bus.alu_out) !== exp_alu) begin
        errors++; $display("FAIL conc_alu%0d actual=%h required=%h", i, bus.alu_out, exp_alu);
      end
      vectors++;
      if (int'(bus.cnt_q) !== exp_cnt || bus.cnt_zero !== (exp_cnt == 0)) begin
        errors++; $display("FAIL conc_cnt%0d actual=%0d/%b required=%0d/%b", i, bus.cnt_q, bus.cnt_zero, exp_cnt, exp_cnt == 0);
      end
    end
    bus.cnt_load = 1'b0; bus.cnt_dec = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_count();
    test_priority_hold();
    test_mux();
    test_concurrent(8, 1'b1);
    test_concurrent(200, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
